// File: rtl/i2c_pkg.sv
// i2c_pkg: FSM states, quarter-phase codes and frame length shared by i2c_reg_writer
// Contents: state_e (IDLE..STOP), Q0..Q3 quarter phases, FRAME_QTRS (quarters per full frame).
package i2c_pkg;
  typedef enum logic [3:0] {IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP} state_e;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam int FRAME_QTRS = 116;
endpackage

// File: rtl/i2c_qtr_tick.sv
// i2c_qtr_tick: free-running QTR_DIV counter emitting a strobe on the last cycle of each SCL quarter
// Ports: i_clk clock; i_rst sync reset; i_clr restart the quarter (on accept); o_tick quarter-end strobe.
module i2c_qtr_tick #(
  parameter int QTR_DIV = 31
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);
  localparam int W = $clog2(QTR_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign o_tick = cnt_q == W'(QTR_DIV - 1);
  always_comb cnt_d = o_tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge i_clk) cnt_q <= (i_rst || i_clr) ? '0 : cnt_d;
endmodule

// File: rtl/i2c_reg_writer.sv
// i2c_reg_writer: single-master I2C register write (START, dev+W, reg, data, STOP), MSB first
// Ports: i_clk/i_rst clock and sync reset; i_valid/o_ready request handshake with i_dev_addr,
// i_reg_addr, i_data; o_busy/o_done/o_nack status; I2C_SCL, I2C_SDA_O/I2C_SDA_OE/I2C_SDA_I bus pins.
// Define I2C_REG_WRITER_ACK_CHECK_EN to jump to STOP on a slave NACK and report it on o_nack.
module i2c_reg_writer
  import i2c_pkg::*;
#(
  parameter int QTR_DIV = 31
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [6:0] i_dev_addr,
  input  logic [7:0] i_reg_addr,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_nack,
  output logic       I2C_SCL,
  output logic       I2C_SDA_O,
  output logic       I2C_SDA_OE,
  input  logic       I2C_SDA_I
);
  state_e state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d, dat_q, dat_d, byte_w;
  logic nack_q, nack_d, done_q, done_d, tick, accept, is_ack, ack_smp;
  assign accept = i_valid && o_ready;
  i2c_qtr_tick #(.QTR_DIV(QTR_DIV)) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (accept),
    .o_tick(tick)
  );
`ifdef I2C_REG_WRITER_ACK_CHECK_EN
  assign ack_smp = I2C_SDA_I;
`else
  logic unused_sda;
  assign unused_sda = I2C_SDA_I;
  assign ack_smp = 1'b0;
`endif
  assign is_ack = state_q == ACK1 || state_q == ACK2 || state_q == ACK3;
  assign byte_w = state_q == ADDR ? {dev_q, 1'b0} : state_q == REG ? reg_q : dat_q;
  assign done_d = tick && qtr_q == Q3 && state_q == STOP;
  assign o_ready = state_q == IDLE;
  assign o_busy = !o_ready;
  assign o_done = done_q;
  assign o_nack = nack_q;
  assign I2C_SDA_O = 1'b0;
  always_comb begin
    state_d = state_q;
    qtr_d = qtr_q;
    bit_d = bit_q;
    dev_d = dev_q;
    reg_d = reg_q;
    dat_d = dat_q;
    // ACK is taken on the last cycle of Q2, while SCL is still high
    nack_d = nack_q | (is_ack && qtr_q == Q2 && tick && ack_smp);
    if (accept) begin
      state_d = START;
      qtr_d = Q0;
      bit_d = 3'd7;
      dev_d = i_dev_addr;
      reg_d = i_reg_addr;
      dat_d = i_data;
      nack_d = 1'b0;
    end else if (tick && state_q != IDLE) begin
      qtr_d = qtr_q + 2'd1;
      if (qtr_q == Q3) begin
        // bit counter wraps 0 -> 7, so it is ready for the next byte without a reload
        if (state_q == ADDR || state_q == REG || state_q == DATA) bit_d = bit_q - 3'd1;
        case (state_q)
          START:   state_d = ADDR;
          ADDR:    state_d = bit_q == 3'd0 ? ACK1 : ADDR;
          ACK1:    state_d = nack_q ? STOP : REG;
          REG:     state_d = bit_q == 3'd0 ? ACK2 : REG;
          ACK2:    state_d = nack_q ? STOP : DATA;
          DATA:    state_d = bit_q == 3'd0 ? ACK3 : DATA;
          ACK3:    state_d = STOP;
          default: state_d = IDLE;
        endcase
      end
    end
  end
  always_comb begin
    I2C_SCL = qtr_q == Q1 || qtr_q == Q2;
    I2C_SDA_OE = 1'b0;
    case (state_q)
      IDLE: I2C_SCL = 1'b1;
      START: begin
        I2C_SCL = qtr_q <= Q1;
        I2C_SDA_OE = qtr_q != Q0;
      end
      STOP: begin
        I2C_SCL = qtr_q != Q0;
        I2C_SDA_OE = qtr_q <= Q1;
      end
      ACK1, ACK2, ACK3: I2C_SDA_OE = 1'b0;
      default: I2C_SDA_OE = ~byte_w[bit_q];
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      qtr_q <= Q0;
      bit_q <= '0;
      dev_q <= '0;
      reg_q <= '0;
      dat_q <= '0;
      nack_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      qtr_q <= qtr_d;
      bit_q <= bit_d;
      dev_q <= dev_d;
      reg_q <= reg_d;
      dat_q <= dat_d;
      nack_q <= nack_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_i2c_reg_writer.sv
// tb_i2c_reg_writer: self-checking bench with an I2C slave/bus monitor and frame-level reference model
module tb_i2c_reg_writer;
  localparam int QD = 4;
`ifdef I2C_REG_WRITER_ACK_CHECK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif
  typedef struct {
    logic [6:0] a;
    logic [7:0] r;
    logic [7:0] d;
    logic [2:0] m;
    int         nb;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         cyc;
    logic       nk;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0;
  logic ready, busy, done, nack, scl, sda_o, sda_oe, sda_i;
  logic [6:0] dev = '0;
  logic [7:0] regad = '0, data = '0;
  logic slave_low = 1'b0, mon_en = 1'b0;
  logic [2:0] nack_mask = '0;
  logic p_scl = 1'b1, p_sda = 1'b1;
  logic [7:0] sh = '0;
  logic [7:0] rx_q[$];
  int starts = 0, stops = 0, viol = 0, bitn = 0, byte_i = 0;
  int n_chk = 0, n_fail = 0;
  vec_t tv[5];
  always #5 clk = ~clk;
  assign sda_i = ~(sda_oe | slave_low);
  i2c_reg_writer #(.QTR_DIV(QD)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_dev_addr(dev), .i_reg_addr(regad), .i_data(data),
    .o_busy(busy), .o_done(done), .o_nack(nack),
    .I2C_SCL(scl), .I2C_SDA_O(sda_o), .I2C_SDA_OE(sda_oe), .I2C_SDA_I(sda_i)
  );
  // bus monitor + slave: decodes START/STOP/bytes on the wire and ACKs unless nack_mask says otherwise
  always @(negedge clk) begin
    if (sda_o !== 1'b0) viol <= viol + 1;
    if (rst || !mon_en) begin
      slave_low <= 1'b0;
      bitn <= 0;
      byte_i <= 0;
    end else if (p_scl && scl && p_sda && !sda_i) begin
      starts <= starts + 1;
      bitn <= 0;
      byte_i <= 0;
    end else if (p_scl && scl && !p_sda && sda_i) begin
      stops <= stops + 1;
    end else if (!p_scl && scl) begin
      if (bitn == 8) begin
        bitn <= 0;
        byte_i <= byte_i + 1;
      end else begin
        sh <= {sh[6:0], sda_i};
        bitn <= bitn + 1;
        if (bitn == 7) rx_q.push_back({sh[6:0], sda_i});
      end
    end else if (p_scl && !scl) begin
      slave_low <= bitn == 8 && !(byte_i < 3 && nack_mask[byte_i]);
    end else if (p_scl != scl || p_sda != sda_i) begin
      if (scl && p_scl) viol <= viol + 1;
    end
    p_scl <= scl;
    p_sda <= sda_i;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference: a NACK (when honoured) ends the frame after that byte's ACK; each byte+ACK is 36 quarters
  function automatic void model(input logic [2:0] m, output int nb, output int cyc, output logic nk);
    nb = 3;
    nk = 1'b0;
    if (ACK)
      for (int i = 2; i >= 0; i--)
        if (m[i]) begin
          nb = i + 1;
          nk = 1'b1;
        end
    cyc = QD * (4 + 36 * nb + 4);
  endfunction
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask
  task automatic check_bytes(input string tag, input int rx0, input int st0, input int sp0, input int v0, input vec_t v);
    logic [7:0] eb[3];
    eb[0] = v.b0;
    eb[1] = v.b1;
    eb[2] = v.b2;
    check({tag, ".nbytes"}, rx_q.size() - rx0, v.nb);
    for (int i = 0; i < v.nb; i++)
      check($sformatf("%s.byte%0d", tag, i), (rx0 + i < rx_q.size()) ? rx_q[rx0 + i] : 8'hxx, eb[i]);
    check({tag, ".starts"}, starts - st0, 1);
    check({tag, ".stops"}, stops - sp0, 1);
    check({tag, ".protocol"}, viol - v0, 0);
  endtask
  task automatic run_frame(input vec_t v, input string tag);
    int rx0, st0, sp0, v0, cyc, w;
    nack_mask = v.m;
    w = 0;
    while (ready !== 1'b1 && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    rx0 = rx_q.size();
    st0 = starts;
    sp0 = stops;
    v0 = viol;
    dev = v.a;
    regad = v.r;
    data = v.d;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    dev = 7'($urandom);
    regad = 8'($urandom);
    data = 8'($urandom);
    check({tag, ".busy"}, busy, 1);
    wait_done(cyc);
    check({tag, ".cycles"}, cyc, v.cyc);
    check({tag, ".nack"}, nack, v.nk);
    check({tag, ".ready"}, ready, 1);
    check({tag, ".idle"}, busy, 0);
    check_bytes(tag, rx0, st0, sp0, v0, v);
  endtask
  initial begin
    int cyc, rx0, st0, sp0, v0;
    vec_t v;
    tv[0] = '{7'h10, 8'h0A, 8'h5C, 3'b000, 3, 8'h20, 8'h0A, 8'h5C, 464, 1'b0};
    tv[1] = '{7'h10, 8'h0A, 8'h5C, 3'b001, ACK ? 1 : 3, 8'h20, 8'h0A, 8'h5C, ACK ? 176 : 464, ACK};
    tv[2] = '{7'h7F, 8'hFF, 8'h00, 3'b000, 3, 8'hFE, 8'hFF, 8'h00, 464, 1'b0};
    tv[3] = '{7'h00, 8'h00, 8'hFF, 3'b010, ACK ? 2 : 3, 8'h00, 8'h00, 8'hFF, ACK ? 320 : 464, ACK};
    tv[4] = '{7'h55, 8'hA5, 8'h3C, 3'b100, 3, 8'hAA, 8'hA5, 8'h3C, 464, ACK};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.ready", ready, 1);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.nack", nack, 0);
    check("rst.scl", scl, 1);
    check("rst.sda_oe", sda_oe, 0);
    check("rst.sda_o", sda_o, 0);
    mon_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) run_frame(tv[i], $sformatf("tv%0d", i));
    // back-to-back: valid held high, inputs change after each accept
    nack_mask = '0;
    rx0 = rx_q.size(); st0 = starts; sp0 = stops; v0 = viol;
    dev = 7'h21; regad = 8'h43; data = 8'h65; valid = 1'b1;
    @(posedge clk); #1;
    dev = 7'h3A; regad = 8'hC3; data = 8'h96;
    wait_done(cyc);
    check("b2b1.cycles", cyc, 464);
    check("b2b1.ready", ready, 1);
    check_bytes("b2b1", rx0, st0, sp0, v0, '{7'h21, 8'h43, 8'h65, 3'b000, 3, 8'h42, 8'h43, 8'h65, 464, 1'b0});
    rx0 = rx_q.size(); st0 = starts; sp0 = stops; v0 = viol;
    @(posedge clk); #1;
    check("b2b2.restart_busy", busy, 1);
    check("b2b2.done_pulse", done, 0);
    dev = 7'h0F; regad = 8'h11; data = 8'h22; valid = 1'b0;
    wait_done(cyc);
    check("b2b2.cycles", cyc, 464);
    check_bytes("b2b2", rx0, st0, sp0, v0, '{7'h3A, 8'hC3, 8'h96, 3'b000, 3, 8'h74, 8'hC3, 8'h96, 464, 1'b0});
    // reset 100 cycles into a frame
    nack_mask = 3'b111;
    dev = 7'h33; regad = 8'h44; data = 8'h55; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.scl", scl, 1);
    check("abort.sda_oe", sda_oe, 0);
    check("abort.ready", ready, 1);
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.nack", nack, 0);
    run_frame(tv[0], "post_rst");
    for (int k = 0; k < 8; k++) begin
      v.a = 7'($urandom);
      v.r = 8'($urandom);
      v.d = 8'($urandom);
      v.m = k < 3 ? 3'b000 : 3'($urandom_range(0, 7));
      model(v.m, v.nb, v.cyc, v.nk);
      v.b0 = {v.a, 1'b0};
      v.b1 = v.r;
      v.b2 = v.d;
      run_frame(v, $sformatf("rnd%0d", k));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_reg_writer.md
I2C_REG_WRITER -- requirements
Module: i2c_reg_writer

Interface
REQ-001 Parameter: QTR_DIV, default 31, i_clk cycles per SCL quarter-period; legal range 2..1023.
REQ-002 i_clk  in  1  single clock; all logic on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_valid  in  1  write request valid.
REQ-005 o_ready  out  1  high in IDLE; request accepted on i_valid && o_ready.
REQ-006 i_dev_addr  in  7  7-bit I2C slave address.
REQ-007 i_reg_addr  in  8  target register address.
REQ-008 i_data  in  8  register write data.
REQ-009 o_busy  out  1  high from accept cycle +1 until done pulse.
REQ-010 o_done  out  1  one-cycle pulse at end of frame.
REQ-011 o_nack  out  1  frame ended on NACK; valid with o_done, held until next accept.
REQ-012 I2C_SCL  out  1  SCL level, master-only; no clock stretching.
REQ-013 I2C_SDA_O  out  1  SDA drive value, constant 0.
REQ-014 I2C_SDA_OE  out  1  1 = pull SDA low; 0 = release (pull-up gives 1).
REQ-015 I2C_SDA_I  in  1  sampled SDA bus level.

Function
REQ-016 On accept, latch dev_addr, reg_addr and data; later input changes are ignored.
REQ-017 i_valid while busy is ignored; no queuing.
REQ-018 Frame: START, byte {dev_addr,0}, ACK1, reg_addr, ACK2, data, ACK3, STOP; bytes MSB first.
REQ-019 FSM states: IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP.
REQ-020 Every state except IDLE lasts 4 quarters (Q0..Q3) of QTR_DIV cycles each; quarter counter wraps QTR_DIV-1 -> 0.
REQ-021 START: Q0 SCL=1/SDA released; Q1 SDA low; Q2-Q3 SCL=0, SDA low.
REQ-022 Data bit: Q0 SCL=0, SDA set to bit; Q1-Q2 SCL=1; Q3 SCL=0; SDA is stable while SCL is high.
REQ-023 ACK bit: SDA released all 4 quarters; I2C_SDA_I is sampled on the last cycle of Q2; 1 = NACK.
REQ-024 STOP: Q0 SCL=0/SDA low; Q1 SCL=1/SDA low; Q2 SDA released; Q3 idle-level bus.
REQ-025 A bit counter (3 bits) selects bit 7..0 and advances to the ACK state after bit 0.
REQ-026 Nominal frame length: 116*QTR_DIV cycles from the accept edge to the o_done pulse.
REQ-027 On STOP Q3 end: o_done=1 for one cycle, FSM to IDLE, o_ready=1 the same cycle.
REQ-028 A new request accepted in the o_done cycle is legal and starts START on the next cycle.
REQ-029 In IDLE: SCL=1, SDA_OE=0.

Reset
REQ-030 i_rst forces: state IDLE, SCL=1, SDA_OE=0, SDA_O=0, o_ready=1, o_busy=0, o_done=0, o_nack=0, counters 0.
REQ-031 Reset mid-frame aborts immediately with no STOP generated; the next request starts a fresh START.

Configuration
REQ-032 Macro I2C_REG_WRITER_ACK_CHECK_EN, when defined: a NACK at any ACK state skips the remaining bytes, goes to STOP, and sets o_nack=1 with o_done.
REQ-033 Without the macro: ACK samples are ignored, the full frame is always sent, and o_nack is constant 0.

Structure
REQ-034 Package i2c_pkg holds the FSM state enum, quarter-phase constants Q0..Q3, and the 116-quarter frame-length constant.
REQ-035 Sub-module i2c_qtr_tick: counter with parameter QTR_DIV emitting a quarter-end strobe; cleared on i_rst and on accept.

Verification
REQ-036 QTR_DIV=4, dev 0x10, reg 0x0A, data 0x5C, ACKing slave -> SDA bytes 0x20, 0x0A, 0x5C; o_done 464 cycles after accept; o_nack=0.
REQ-037 Slave NACKs the address, macro defined -> STOP follows ACK1; o_done at (4+9*4+4)*4=176 cycles; o_nack=1.
REQ-038 Same NACK, macro undefined -> all 3 bytes sent; o_done at 464 cycles; o_nack=0.
REQ-039 i_valid held high with changing data -> two back-to-back frames with first-latched values; second START on the cycle after o_done.
REQ-040 i_rst at cycle 100 of a frame -> next cycle SCL=1, SDA_OE=0, o_ready=1; a following request completes normally.
REQ-041 Protocol checker throughout: SDA never changes while SCL=1 except at START/STOP; SDA_O is always 0.
